// File: rtl/conv_sched_pkg.sv
// Shared constants and FSM state encoding for the convolution job sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package conv_pkg;
  localparam int WIN_W      = 72;  // 9 x 8-bit pixel window
  localparam int OUT_W      = 32;  // conv result width
  localparam int CNT_W      = 16;  // job length counter width
  localparam int FIFO_DEPTH = 8;   // result skid entries, must cover conv latency + 1
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    RUN,
    DRAIN,
    FLUSH,
    DONE
  } state_t;
endpackage

// File: rtl/conv_sched_fifo.sv
// Synchronous result FIFO with occupancy count and synchronous clear.
// Latency: push visible at the read port on the following cycle.
// Backpressure: push ignored when full unless a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & ((count != (AW+1)'(DEPTH)) | do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/conv_sched.sv
// Sequences one conv job: gates windows into the core, frames results (m_last) for the writer.
// Latency: window issue to FIFO = conv core latency; FIFO push to m_valid = 1 cycle.
// Backpressure: credits (FIFO occupancy + in-flight) stop issue before the result FIFO can overrun.
module conv_sched
  import conv_pkg::*;
(
  input  logic             aclk,
  input  logic             areset,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             w_valid,
  input  logic             p_valid,
  input  logic             p_last,
  output logic             p_ready,
  output logic             conv_p_valid,
  input  logic             o_valid,
  input  logic [OUT_W-1:0] o,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             err_len
);
  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   len_m1;
  logic [CNT_W-1:0]   issued;
  logic [CNT_W-1:0]   retired;
  logic [FIFO_AW:0]   inflight;
  logic [FIFO_AW:0]   fifo_count;
  logic [FIFO_AW+1:0] occ;
  logic               credit_ok;
  logic               issue;
  logic               ret_ok;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_clr;
  logic               start_ok;

  // Issue gating depends only on registered state so p_ready never loops back through p_valid.
  assign len_m1       = len_q - 1'b1;
  assign occ          = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok    = occ < (FIFO_AW+2)'(FIFO_DEPTH);
  assign p_ready      = (state == RUN) & credit_ok & (issued < len_q);
  assign issue        = p_valid & p_ready;
  assign conv_p_valid = issue;

  // A stray result with nothing in flight is dropped so inflight cannot underflow.
  assign ret_ok   = o_valid & (inflight != '0);
  assign start_ok = (state == IDLE) & cfg_start & ~cfg_abort;
  assign fifo_clr = (state != FLUSH) & (state_nxt == FLUSH);
  assign push     = ret_ok & (state != FLUSH);
  assign m_valid  = ~fifo_empty & (state != FLUSH);
  assign pop      = m_valid & m_ready;
  assign m_last   = m_valid & (retired == len_m1);

  sync_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .clr       (fifo_clr),
    .push      (push),
    .push_data (o),
    .pop       (pop),
    .pop_data  (m_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs; abort takes priority over normal progress.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    unique case (state)
      IDLE:   if (start_ok) state_nxt = (cfg_len == '0) ? DONE : WAIT_W;
      WAIT_W: if (cfg_abort) state_nxt = FLUSH;
              else if (w_valid) state_nxt = RUN;
      RUN:    if (cfg_abort) state_nxt = FLUSH;
              else if (issued == len_q) state_nxt = DRAIN;
      DRAIN:  if (cfg_abort) state_nxt = FLUSH;
              else if (retired == len_q) state_nxt = DONE;
      FLUSH:  if (inflight == '0) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job counters: length latched and progress cleared on an accepted start.
  always_ff @(posedge aclk) begin
    if (areset) begin
      len_q   <= '0;
      issued  <= '0;
      retired <= '0;
    end else if (start_ok) begin
      len_q   <= cfg_len;
      issued  <= '0;
      retired <= '0;
    end else begin
      if (issue) issued  <= issued + 1'b1;
      if (pop)   retired <= retired + 1'b1;
    end
  end

  // In-flight tracking for the fixed-latency core; simultaneous issue and return cancel.
  always_ff @(posedge aclk) begin
    if (areset) begin
      inflight <= '0;
    end else begin
      case ({issue, ret_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Sticky length error: p_last must coincide exactly with window len-1.
  always_ff @(posedge aclk) begin
    if (areset || start_ok) err_len <= 1'b0;
    else if (issue && (p_last != (issued == len_m1))) err_len <= 1'b1;
  end
endmodule

// File: tb/tb_conv_sched.sv
// Randomized bench for conv_sched with a fixed-latency conv model and a result scoreboard.
// Latency: conv model returns each issued window LAT cycles later.
// Backpressure: m_ready is driven randomly or held low to exercise credit limits.
module tb_conv_sched;
  import conv_pkg::*;

  localparam int LAT = 3;

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic             cfg_start = 1'b0;
  logic             cfg_abort = 1'b0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic             w_valid = 1'b0;
  logic             p_valid = 1'b0;
  logic             p_last = 1'b0;
  logic             p_ready;
  logic             conv_p_valid;
  logic             o_valid;
  logic [OUT_W-1:0] o;
  logic             m_valid;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
  logic             m_ready = 1'b0;
  logic             busy;
  logic             done;
  logic             err_len;

  logic [OUT_W-1:0] win = '0;
  logic [OUT_W:0]   exp_q [$];
  int               total = 0;
  int               bad = 0;
  int               n_out = 0;
  bit               in_abort = 1'b0;

  always #5 aclk = ~aclk;

  conv_sched dut (
    .aclk (aclk), .areset (areset), .cfg_start (cfg_start), .cfg_abort (cfg_abort),
    .cfg_len (cfg_len), .w_valid (w_valid), .p_valid (p_valid), .p_last (p_last),
    .p_ready (p_ready), .conv_p_valid (conv_p_valid), .o_valid (o_valid), .o (o),
    .m_valid (m_valid), .m_data (m_data), .m_last (m_last), .m_ready (m_ready),
    .busy (busy), .done (done), .err_len (err_len)
  );

  // Conv core model: every issued window comes back LAT cycles later, never stalls.
  logic [LAT-1:0]   pv;
  logic [OUT_W-1:0] pd [LAT];
  always @(posedge aclk) begin
    if (areset) pv <= '0;
    else        pv <= {pv[LAT-2:0], conv_p_valid};
    pd[0] <= win;
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end
  assign o_valid = pv[LAT-1];
  assign o       = pd[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted result and checks output stability.
  bit             hold_prev = 1'b0;
  logic [OUT_W:0] prev_out = '0;
  always @(negedge aclk) begin
    logic [OUT_W:0] e;
    if (!areset) begin
      if (hold_prev && !in_abort) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", {m_last, m_data}, prev_out);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got data %0d with no result pending", m_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_data, e[OUT_W-1:0]);
          check("out_last", m_last, e[OUT_W]);
        end
        n_out++;
      end
      hold_prev = m_valid && !m_ready && !in_abort;
      prev_out  = {m_last, m_data};
    end
  end

  // One job: random pacing, optional m_ready hold-off, late weights, misplaced p_last, restart attempt.
  task automatic run_job(input int len, input int pv_pct, input int mr_pct, input int mr_hold,
                         input int last_pos, input int wv_delay, input int restart_at);
    int  issued_n = 0;
    int  c = 0;
    int  early = 0;
    int  out0 = n_out;
    bit  seen = 1'b0;
    bit  exp_err = (len > 0) && (last_pos != len - 1);
    w_valid   = (wv_delay == 0);
    cfg_len   = len[CNT_W-1:0];
    cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
    while (!seen && c < 3000) begin
      p_valid = ($urandom_range(99) < pv_pct);
      win     = $urandom();
      p_last  = (issued_n == last_pos);
      m_ready = (c >= mr_hold) && ($urandom_range(99) < mr_pct);
      if (c >= wv_delay) w_valid = 1'b1;
      cfg_start = (c == restart_at);
      if (c == restart_at) cfg_len = 9;
      @(negedge aclk);
      if (c == 0) check("busy_in_job", busy, 1);
      if (!w_valid && p_ready) early++;
      if (mr_hold > 0 && c == mr_hold - 1) check("credit_cap", issued_n, FIFO_DEPTH);
      if (p_valid && p_ready) begin
        exp_q.push_back({(issued_n == len - 1), win});
        issued_n++;
      end
      if (done) seen = 1'b1;
      c++;
      @(posedge aclk); #1;
    end
    cfg_start = 1'b0;
    check("done_seen", seen, 1);
    if (len == 0) check("len0_done_delay", c, 1);
    check("issued_cnt", issued_n, len);
    check("out_cnt", n_out - out0, len);
    check("err_len", err_len, exp_err);
    check("early_pready", early, 0);
    @(negedge aclk);
    check("done_pulse_width", done, 0);
    check("idle_busy", busy, 0);
    @(posedge aclk); #1;
  endtask

  initial begin
    int n;
    int c;
    int mv;
    int pr;
    bit seen;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_p_ready", p_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_len", err_len, 0);
    check("rst_conv_p_valid", conv_p_valid, 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;

    run_job(4, 100, 100, 0, 3, 0, -1);       // basic in-order run
    run_job(16, 100, 100, 40, 15, 0, -1);    // credit limit while writer stalls
    run_job(5, 100, 100, 0, 4, 10, -1);      // weights arrive late
    run_job(6, 100, 100, 0, 2, 0, -1);       // early p_last flags err_len
    run_job(3, 100, 100, 0, 2, 0, -1);       // err_len cleared by next start

    // Abort after three windows issued with the writer stalled.
    in_abort  = 1'b1;
    w_valid   = 1'b1;
    m_ready   = 1'b0;
    p_last    = 1'b0;
    cfg_len   = 10;
    cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
    n = 0;
    c = 0;
    while (n < 3 && c < 100) begin
      p_valid = 1'b1;
      win     = $urandom();
      @(negedge aclk);
      if (p_valid && p_ready) n++;
      c++;
      @(posedge aclk); #1;
    end
    check("abort_pre_issued", n, 3);
    p_valid   = 1'b0;
    cfg_abort = 1'b1;
    @(posedge aclk); #1;
    cfg_abort = 1'b0;
    p_valid   = 1'b1;
    seen = 1'b0;
    mv   = 0;
    pr   = 0;
    c    = 0;
    while (!seen && c < 50) begin
      @(negedge aclk);
      if (m_valid) mv++;
      if (m_last)  mv++;
      if (p_ready) pr++;
      if (done) seen = 1'b1;
      c++;
    end
    check("abort_done", seen, 1);
    check("abort_m_valid", mv, 0);
    check("abort_p_ready", pr, 0);
    repeat (4) @(negedge aclk);
    check("abort_fifo_empty", m_valid, 0);
    check("abort_idle", busy, 0);
    @(posedge aclk); #1;
    p_valid  = 1'b0;
    in_abort = 1'b0;

    run_job(3, 100, 100, 0, 2, 0, -1);       // clean job after abort
    run_job(0, 100, 100, 0, -1, 0, -1);      // zero-length job
    run_job(4, 100, 100, 0, 3, 6, 2);        // start while busy is ignored
    for (int k = 0; k < 4; k++) begin
      int len = $urandom_range(20, 1);
      run_job(len, $urandom_range(100, 30), $urandom_range(100, 30), 0, len - 1, 0, -1);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
